// File: rtl/kmeans_pkg.sv
// rtl/kmeans_pkg.sv - shared defaults and width helpers for the k-means classifier
package kmeans_pkg;

  localparam int KM_K_DEF       = 8;
  localparam int KM_DIMS_DEF    = 7;
  localparam int KM_COORD_W_DEF = 13;
  localparam int KM_ACC_W_DEF   = 22;
  localparam int KM_CNT_W_DEF   = 10;

  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int idx_w(input int k);
    return (k > 1) ? clog2_int(k) : 1;
  endfunction

  function automatic int dist_w(input int coord_w, input int dims);
    return 2 * coord_w + clog2_int(dims);
  endfunction

endpackage

// File: rtl/kmeans_argmin_tree.sv
// rtl/kmeans_argmin_tree.sv - registered min-distance tree over K masked slots
// Ties resolve to the lowest slot because the left subtree always wins on equality.
module kmeans_argmin_tree
  import kmeans_pkg::*;
#(
  parameter int K      = KM_K_DEF,
  parameter int DIST_W = dist_w(KM_COORD_W_DEF, KM_DIMS_DEF),
  localparam int IDX_W = idx_w(K)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic [K-1:0]          mask_i,
  input  logic [K*DIST_W-1:0]   dist_i,
  output logic                  out_valid_o,
  output logic [IDX_W-1:0]      out_idx_o,
  output logic [DIST_W-1:0]     out_dist_o
);

  localparam int P = 1 << clog2_int(K);

  function automatic logic [IDX_W+DIST_W-1:0] pick_min(input logic [K*DIST_W-1:0] d,
                                                        input logic [K-1:0] m);
    logic [DIST_W-1:0] nd [2*P-1];
    logic [IDX_W-1:0]  ni [2*P-1];
    logic              nv [2*P-1];
    for (int n = 0; n < 2*P-1; n++) begin
      nd[n] = '0;
      ni[n] = '0;
      nv[n] = 1'b0;
    end
    for (int s = 0; s < K; s++) begin
      nd[P-1+s] = d[s*DIST_W +: DIST_W];
      ni[P-1+s] = IDX_W'(s);
      nv[P-1+s] = m[s];
    end
    for (int n = P-2; n >= 0; n--) begin
      if (nv[2*n+2] && (!nv[2*n+1] || nd[2*n+2] < nd[2*n+1])) begin
        nd[n] = nd[2*n+2];
        ni[n] = ni[2*n+2];
        nv[n] = 1'b1;
      end else begin
        nd[n] = nd[2*n+1];
        ni[n] = ni[2*n+1];
        nv[n] = nv[2*n+1];
      end
    end
    return {ni[0], nd[0]};
  endfunction

  logic [IDX_W-1:0]  min_idx;
  logic [DIST_W-1:0] min_dist;

  always_comb begin
    {min_idx, min_dist} = pick_min(dist_i, mask_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_idx_o   <= '0;
      out_dist_o  <= '0;
    end else begin
      out_valid_o <= in_valid_i;
      out_idx_o   <= min_idx;
      out_dist_o  <= min_dist;
    end
  end

endmodule

// File: rtl/kmeans_classify_stream.sv
// rtl/kmeans_classify_stream.sv - streaming nearest-centroid classifier with per-slot accumulators
// KMEANS_ACC_SAT_EN selects saturating accumulators/counts with a sticky ovf; otherwise they wrap.
module kmeans_classify_stream
  import kmeans_pkg::*;
#(
  parameter int K       = KM_K_DEF,
  parameter int DIMS    = KM_DIMS_DEF,
  parameter int COORD_W = KM_COORD_W_DEF,
  parameter int ACC_W   = KM_ACC_W_DEF,
  parameter int CNT_W   = KM_CNT_W_DEF,
  localparam int IDX_W  = idx_w(K),
  localparam int DIST_W = dist_w(COORD_W, DIMS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cent_wr_en,
  input  logic [IDX_W-1:0]            cent_wr_idx,
  input  logic [DIMS*COORD_W-1:0]     cent_wr_data,
  input  logic [IDX_W:0]              active_k,
  input  logic                        pt_valid,
  output logic                        pt_ready,
  input  logic [DIMS*COORD_W-1:0]     pt_data,
  input  logic                        acc_clear,
  output logic                        res_valid,
  output logic [IDX_W-1:0]            res_idx,
  output logic [DIST_W-1:0]           res_dist,
  output logic [K*DIMS*ACC_W-1:0]     accum_flat,
  output logic [K*CNT_W-1:0]          cnt_flat,
  output logic [K*DIMS*COORD_W-1:0]   centroid_flat,
  output logic                        busy,
  output logic                        wr_err,
  output logic                        ovf
);

  localparam int PT_W = DIMS * COORD_W;
  localparam int KA_W = IDX_W + 1;
`ifdef KMEANS_ACC_SAT_EN
  localparam int XW = 1;
`else
  localparam int XW = 0;
`endif
  localparam int AW = ACC_W + XW;
  localparam int CW = CNT_W + XW;

  logic [PT_W-1:0]   cent_q [K];
  logic [ACC_W-1:0]  acc_q  [K][DIMS];
  logic [CNT_W-1:0]  cnt_q  [K];
  logic              wr_err_q;

  logic              s1_vld_q, s2_vld_q, s3_vld;
  logic [PT_W-1:0]   s1_pt_q, s2_pt_q, s3_pt_q;
  logic [K-1:0]      s1_mask_q, s2_mask_q, mask_d;
  logic [K*DIST_W-1:0] s2_dist_q, dist_d;
  logic [IDX_W-1:0]  s3_idx;
  logic [DIST_W-1:0] s3_dist;

  logic              res_vld_q;
  logic [IDX_W-1:0]  res_idx_q;
  logic [DIST_W-1:0] res_dist_q;

  logic              accept, inflight;
  logic [AW-1:0]     acc_sum [DIMS];
  logic [ACC_W-1:0]  acc_wr  [DIMS];
  logic [CW-1:0]     cnt_sum;
  logic [CNT_W-1:0]  cnt_wr;

  assign pt_ready  = !rst && !acc_clear && !cent_wr_en;
  assign accept    = pt_valid && pt_ready;
  assign inflight  = s1_vld_q | s2_vld_q | s3_vld;
  assign busy      = inflight & ~rst;
  assign res_valid = res_vld_q & ~rst;
  assign res_idx   = res_idx_q;
  assign res_dist  = res_dist_q;
  assign wr_err    = wr_err_q;

  function automatic logic [DIST_W-1:0] sq_dist(input logic [PT_W-1:0] a, input logic [PT_W-1:0] b);
    logic [COORD_W-1:0]   x, y, diff;
    logic [2*COORD_W-1:0] sq;
    logic [DIST_W-1:0]    acc;
    acc = '0;
    for (int d = 0; d < DIMS; d++) begin
      x    = a[d*COORD_W +: COORD_W];
      y    = b[d*COORD_W +: COORD_W];
      diff = (x > y) ? x - y : y - x;
      sq   = {{COORD_W{1'b0}}, diff} * {{COORD_W{1'b0}}, diff};
      acc  = acc + DIST_W'(sq);
    end
    return acc;
  endfunction

  // Slot 0 is always eligible, so active_k = 0 behaves as 1 and oversize values enable every slot.
  always_comb begin
    mask_d = '0;
    for (int s = 0; s < K; s++) mask_d[s] = (s == 0) || (int'(active_k) > s);
  end

  always_comb begin
    dist_d = '0;
    for (int s = 0; s < K; s++) dist_d[s*DIST_W +: DIST_W] = sq_dist(s1_pt_q, cent_q[s]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s1_pt_q   <= '0;
      s2_pt_q   <= '0;
      s3_pt_q   <= '0;
      s1_mask_q <= '0;
      s2_mask_q <= '0;
      s2_dist_q <= '0;
    end else begin
      s1_vld_q <= accept;
      s2_vld_q <= s1_vld_q;
      if (accept) begin
        s1_pt_q   <= pt_data;
        s1_mask_q <= mask_d;
      end
      s2_pt_q   <= s1_pt_q;
      s2_mask_q <= s1_mask_q;
      s2_dist_q <= dist_d;
      s3_pt_q   <= s2_pt_q;
    end
  end

  kmeans_argmin_tree #(.K(K), .DIST_W(DIST_W)) u_argmin (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (s2_vld_q),
    .mask_i      (s2_mask_q),
    .dist_i      (s2_dist_q),
    .out_valid_o (s3_vld),
    .out_idx_o   (s3_idx),
    .out_dist_o  (s3_dist)
  );

  // Writes must not disturb points already using the centroid table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < K; s++) cent_q[s] <= '0;
      wr_err_q <= 1'b0;
    end else if (cent_wr_en) begin
      if (!inflight && ({1'b0, cent_wr_idx} < KA_W'(K))) cent_q[cent_wr_idx] <= cent_wr_data;
      else wr_err_q <= 1'b1;
    end
  end

  always_comb begin
    cnt_sum = CW'(cnt_q[s3_idx]) + CW'(1);
    for (int d = 0; d < DIMS; d++)
      acc_sum[d] = AW'(acc_q[s3_idx][d]) + AW'(s3_pt_q[d*COORD_W +: COORD_W]);
  end

`ifdef KMEANS_ACC_SAT_EN
  logic sat_hit, ovf_q;
  always_comb begin
    sat_hit = cnt_sum[CNT_W];
    cnt_wr  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    for (int d = 0; d < DIMS; d++) begin
      acc_wr[d] = acc_sum[d][ACC_W] ? '1 : acc_sum[d][ACC_W-1:0];
      sat_hit   = sat_hit | acc_sum[d][ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (s3_vld && !acc_clear && sat_hit) ovf_q <= 1'b1;
  end
  assign ovf = ovf_q;
`else
  always_comb begin
    cnt_wr = cnt_sum;
    for (int d = 0; d < DIMS; d++) acc_wr[d] = acc_sum[d];
  end
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld_q  <= 1'b0;
      res_idx_q  <= '0;
      res_dist_q <= '0;
      for (int s = 0; s < K; s++) begin
        cnt_q[s] <= '0;
        for (int d = 0; d < DIMS; d++) acc_q[s][d] <= '0;
      end
    end else begin
      res_vld_q  <= s3_vld;
      res_idx_q  <= s3_idx;
      res_dist_q <= s3_dist;
      if (acc_clear) begin
        for (int s = 0; s < K; s++) begin
          cnt_q[s] <= '0;
          for (int d = 0; d < DIMS; d++) acc_q[s][d] <= '0;
        end
      end else if (s3_vld) begin
        cnt_q[s3_idx] <= cnt_wr;
        for (int d = 0; d < DIMS; d++) acc_q[s3_idx][d] <= acc_wr[d];
      end
    end
  end

  always_comb begin
    accum_flat    = '0;
    cnt_flat      = '0;
    centroid_flat = '0;
    for (int s = 0; s < K; s++) begin
      centroid_flat[s*PT_W +: PT_W] = cent_q[s];
      cnt_flat[s*CNT_W +: CNT_W]    = cnt_q[s];
      for (int d = 0; d < DIMS; d++) accum_flat[(s*DIMS+d)*ACC_W +: ACC_W] = acc_q[s][d];
    end
  end

endmodule

// File: tb/tb_kmeans_classify_stream.sv
// tb/tb_kmeans_classify_stream.sv - directed self-checking bench for kmeans_classify_stream
module tb_kmeans_classify_stream;

  localparam int K = 8, DIMS = 7, COORD_W = 13, ACC_W = 22, CNT_W = 10;
  localparam int IDX_W = 3, DIST_W = 29, PT_W = DIMS * COORD_W;

  logic                      clk = 1'b0;
  logic                      rst, cent_wr_en, pt_valid, acc_clear;
  logic [IDX_W-1:0]          cent_wr_idx;
  logic [PT_W-1:0]           cent_wr_data, pt_data;
  logic [IDX_W:0]            active_k;
  logic                      pt_ready, res_valid, busy, wr_err, ovf;
  logic [IDX_W-1:0]          res_idx;
  logic [DIST_W-1:0]         res_dist;
  logic [K*DIMS*ACC_W-1:0]   accum_flat;
  logic [K*CNT_W-1:0]        cnt_flat;
  logic [K*PT_W-1:0]         centroid_flat;

  int n_checks = 0;
  int n_errors = 0;

  kmeans_classify_stream dut (
    .clk(clk), .rst(rst), .cent_wr_en(cent_wr_en), .cent_wr_idx(cent_wr_idx),
    .cent_wr_data(cent_wr_data), .active_k(active_k), .pt_valid(pt_valid),
    .pt_ready(pt_ready), .pt_data(pt_data), .acc_clear(acc_clear),
    .res_valid(res_valid), .res_idx(res_idx), .res_dist(res_dist),
    .accum_flat(accum_flat), .cnt_flat(cnt_flat), .centroid_flat(centroid_flat),
    .busy(busy), .wr_err(wr_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [PT_W-1:0] fill(input int v);
    logic [PT_W-1:0] p;
    for (int d = 0; d < DIMS; d++) p[d*COORD_W +: COORD_W] = COORD_W'(v);
    return p;
  endfunction

  function automatic int cnt_of(input int s);
    return int'(cnt_flat[s*CNT_W +: CNT_W]);
  endfunction

  function automatic int acc_of(input int s, input int d);
    return int'(accum_flat[(s*DIMS+d)*ACC_W +: ACC_W]);
  endfunction

  function automatic int cent_of(input int s, input int d);
    return int'(centroid_flat[s*PT_W + d*COORD_W +: COORD_W]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cent(input int idx, input int v);
    cent_wr_en   = 1'b1;
    cent_wr_idx  = IDX_W'(idx);
    cent_wr_data = fill(v);
    step();
    cent_wr_en   = 1'b0;
  endtask

  task automatic send(input int v);
    pt_valid = 1'b1;
    pt_data  = fill(v);
    step();
    pt_valid = 1'b0;
  endtask

  task automatic classify(input string tag, input int v, input int exp_idx, input int exp_dist);
    send(v);
    step();
    step();
    check({tag, "_early"}, 64'(res_valid), 64'd0);
    step();
    check({tag, "_valid"}, 64'(res_valid), 64'd1);
    check({tag, "_idx"}, 64'(res_idx), 64'(exp_idx));
    check({tag, "_dist"}, 64'(res_dist), 64'(exp_dist));
    step();
    check({tag, "_pulse"}, 64'(res_valid), 64'd0);
  endtask

  int vals [3] = '{10, 100, 1000};
  int exps [3] = '{0, 1, 6};

  initial begin
    int nres, first, last, bad_idx, rdy_lo, rv_cnt;
    rst = 1'b1; cent_wr_en = 1'b0; cent_wr_idx = '0; cent_wr_data = '0;
    active_k = 4'd8; pt_valid = 1'b0; pt_data = '0; acc_clear = 1'b0;
    repeat (3) step();
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pt_ready", 64'(pt_ready), 64'd0);
    check("rst_wr_err", 64'(wr_err), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_cnt", 64'(|cnt_flat), 64'd0);
    check("rst_acc", 64'(|accum_flat), 64'd0);
    check("rst_cent", 64'(|centroid_flat), 64'd0);
    rst = 1'b0;
    step();
    check("idle_ready", 64'(pt_ready), 64'd1);

    wr_cent(0, 0);
    wr_cent(1, 100);
    check("cent1_d0", 64'(cent_of(1, 0)), 64'd100);
    check("cent1_d6", 64'(cent_of(1, 6)), 64'd100);
    classify("single", 10, 0, 700);
    check("single_cnt0", 64'(cnt_of(0)), 64'd1);
    check("single_acc0_d0", 64'(acc_of(0, 0)), 64'd10);
    check("single_acc0_d6", 64'(acc_of(0, 6)), 64'd10);
    check("single_cnt1", 64'(cnt_of(1)), 64'd0);

    wr_cent(2, 50);
    wr_cent(5, 50);
    classify("tie", 50, 2, 0);

    wr_cent(6, 1000);
    active_k = 4'd3;
    classify("ak3", 1000, 1, 5670000);
    active_k = 4'd0;
    classify("ak0", 1000, 0, 7000000);
    active_k = 4'd15;
    classify("akbig", 1000, 6, 0);
    active_k = 4'd8;

    acc_clear = 1'b1;
    step();
    acc_clear = 1'b0;
    check("clear_cnt", 64'(|cnt_flat), 64'd0);

    nres = 0; first = -1; last = -1; bad_idx = 0; rdy_lo = 0;
    for (int c = 0; c < 24; c++) begin
      pt_valid = (c < 20);
      pt_data  = fill(vals[c % 3]);
      #1;
      if (c < 20 && !pt_ready) rdy_lo++;
      @(posedge clk);
      #1;
      if (res_valid) begin
        if (first < 0) first = c;
        last = c;
        if (int'(res_idx) != exps[nres % 3]) bad_idx++;
        nres++;
      end
    end
    pt_valid = 1'b0;
    check("stream_ready_low", 64'(rdy_lo), 64'd0);
    check("stream_results", 64'(nres), 64'd20);
    check("stream_first", 64'(first), 64'd3);
    check("stream_contig", 64'(last - first + 1), 64'd20);
    check("stream_bad_idx", 64'(bad_idx), 64'd0);
    check("stream_cnt0", 64'(cnt_of(0)), 64'd7);
    check("stream_cnt1", 64'(cnt_of(1)), 64'd7);
    check("stream_cnt6", 64'(cnt_of(6)), 64'd6);
    check("stream_sum", 64'(cnt_of(0) + cnt_of(1) + cnt_of(6)), 64'd20);
    check("stream_acc6_d3", 64'(acc_of(6, 3)), 64'd6000);

    check("hz_wr_err_pre", 64'(wr_err), 64'd0);
    send(10);
    check("hz_busy", 64'(busy), 64'd1);
    cent_wr_en   = 1'b1;
    cent_wr_idx  = 3'd3;
    cent_wr_data = fill(777);
    step();
    cent_wr_en = 1'b0;
    check("hz_wr_err", 64'(wr_err), 64'd1);
    check("hz_cent3", 64'(cent_of(3, 0)), 64'd0);
    step();
    acc_clear = 1'b1;
    step();
    acc_clear = 1'b0;
    check("hz_clr_valid", 64'(res_valid), 64'd1);
    check("hz_clr_cnt", 64'(|cnt_flat), 64'd0);
    check("hz_clr_acc", 64'(|accum_flat), 64'd0);
    step();

    pt_valid = 1'b1;
    pt_data  = fill(0);
    repeat (1025) step();
    pt_valid = 1'b0;
    repeat (4) step();
`ifdef KMEANS_ACC_SAT_EN
    check("ovf_cnt0", 64'(cnt_of(0)), 64'd1023);
    check("ovf_flag", 64'(ovf), 64'd1);
`else
    check("ovf_cnt0", 64'(cnt_of(0)), 64'd1);
    check("ovf_flag", 64'(ovf), 64'd0);
`endif

    send(100);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(pt_ready), 64'd0);
    rv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) rst = 1'b0;
      step();
      if (res_valid) rv_cnt++;
    end
    check("mid_rst_no_res", 64'(rv_cnt), 64'd0);
    check("mid_rst_wr_err", 64'(wr_err), 64'd0);
    check("mid_rst_cent1", 64'(cent_of(1, 0)), 64'd0);
    check("mid_rst_cnt", 64'(|cnt_flat), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kmeans_classify_stream.md
KMEANS_CLASSIFY_STREAM -- requirements
Module: kmeans_classify_stream

Interface
REQ-001 SHALL have parameter K, default 8, meaning the number of centroid slots (2..16).
REQ-002 SHALL have parameter DIMS, default 7, meaning the number of coordinates per point (1..8).
REQ-003 SHALL have parameter COORD_W, default 13, meaning the unsigned coordinate width.
REQ-004 SHALL have parameter ACC_W, default 22, meaning the per-coordinate accumulator width.
REQ-005 SHALL have parameter CNT_W, default 10, meaning the per-centroid count width.
REQ-006 SHALL have ports, one per line:
- clk  in  1  the single clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- cent_wr_en  in  1  centroid write strobe.
- cent_wr_idx  in  $clog2(K)  centroid slot to write.
- cent_wr_data  in  DIMS*COORD_W  centroid coordinates, coordinate 0 in the LSBs.
- active_k  in  $clog2(K)+1  number of centroids in use.
- pt_valid  in  1  point offered.
- pt_ready  out  1  point accepted when pt_valid and pt_ready are both high.
- pt_data  in  DIMS*COORD_W  point coordinates.
- acc_clear  in  1  clear all accumulators and counts.
- res_valid  out  1  classification result strobe.
- res_idx  out  $clog2(K)  index of the nearest centroid.
- res_dist  out  DIST_W  minimum distance.
- accum_flat  out  K*DIMS*ACC_W  per-centroid coordinate sums, slot 0 in the LSBs.
- cnt_flat  out  K*CNT_W  per-centroid point counts.
- centroid_flat  out  K*DIMS*COORD_W  current centroid registers.
- busy  out  1  high while any point is in flight.
- wr_err  out  1  sticky; set by a rejected centroid write.
- ovf  out  1  sticky; set by saturation.

Function
REQ-007 SHALL use DIST_W = 2*COORD_W + $clog2(DIMS), with distance = sum of squared coordinate differences, computed exactly without truncation.
REQ-008 SHALL use a fixed 3-stage pipeline: point register (S1), distances (S2), argmin (S3).
REQ-009 SHALL, for a point accepted at edge n, assert res_valid for exactly one cycle after edge n+3 and update accum_flat/cnt_flat at edge n+3.
REQ-010 SHALL drive pt_ready = !rst && !acc_clear && !cent_wr_en, so full throughput is one point per cycle, with no output backpressure.
REQ-011 SHALL break argmin ties to the lowest index.
REQ-012 SHALL exclude slots >= active_k from the argmin, using the value sampled with the point at acceptance; active_k = 0 SHALL act as 1 and active_k > K SHALL act as K.
REQ-013 SHALL, on a result, add each point coordinate to the chosen slot's accumulator (zero-extended) and increment its count; other slots SHALL be unchanged.
REQ-014 SHALL apply a centroid write only when busy = 0; a write while busy SHALL be ignored and SHALL set wr_err.
REQ-015 SHALL make an applied write visible on centroid_flat at the next edge and use it for points accepted after that edge.
REQ-016 SHALL, on acc_clear, zero all accumulators and counts at that edge; an in-flight result landing on the same edge SHALL be discarded, with clear winning, while res_valid still fires.
REQ-017 SHALL set busy when any of S1..S3 holds a valid point.
REQ-018 SHALL have all outputs combinationally derived only from registers.

Reset
REQ-019 SHALL, with rst high at an edge, zero all centroid, accumulator, count and pipeline-valid registers and clear wr_err and ovf.
REQ-020 SHALL hold res_valid, busy and pt_ready low while rst is high, and SHALL drop in-flight points on reset mid-operation with no result.

Configuration
REQ-021 SHALL, with KMEANS_ACC_SAT_EN defined, saturate accumulators at 2^ACC_W-1 and counts at 2^CNT_W-1 and set ovf on the first saturation.
REQ-022 SHALL, without KMEANS_ACC_SAT_EN, wrap accumulators and counts modulo 2^width and tie ovf to 0.

Structure
REQ-023 SHALL place DIST_W calculation, clog2 helpers and the default parameter constants in package kmeans_pkg.
REQ-024 SHALL implement the argmin as sub-module kmeans_argmin_tree (parametrised on K and DIST_W), a registered comparison tree whose registers are the S3 register.

Verification
REQ-025 SHALL cover single classification: write c0=(0,..), c1=(100,..) all coordinates, then point all-10 -> res_idx 0, res_dist 700, cnt0 1, accum0 coordinates 10, 3 cycles after acceptance.
REQ-026 SHALL cover ties: c2 = c5 = point -> res_idx 2 and res_dist 0.
REQ-027 SHALL cover active_k: active_k 3 with nearest centroid in slot 6 -> result in slots 0..2 only; active_k 0 -> res_idx 0.
REQ-028 SHALL cover streaming: 20 back-to-back points with pt_valid held high -> pt_ready stays high, 20 contiguous res_valid pulses, counts summing to 20.
REQ-029 SHALL cover hazards: cent_wr_en while busy -> centroid unchanged and wr_err 1; acc_clear coincident with a result -> all accumulators and counts 0.
REQ-030 SHALL cover overflow: 1025 points to slot 0 with CNT_W 10 -> cnt0 1023 and ovf 1 with KMEANS_ACC_SAT_EN, cnt0 1 and ovf 0 without it.
